// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcodes, FSM states and helpers shared by the logic unit lane
package logic_unit_pkg;

    localparam logic [2:0] OP_OR          = 3'b000;
    localparam logic [2:0] OP_AND         = 3'b001;
    localparam logic [2:0] OP_XOR         = 3'b010;
    localparam logic [2:0] OP_NOR         = 3'b011;
    localparam logic [2:0] OP_NAND        = 3'b100;
    localparam logic [2:0] OP_ANDN        = 3'b101;
    localparam logic [2:0] OP_PASSA       = 3'b110;
    localparam logic [2:0] OP_POPCNT_NOTA = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle for logic_unit_pipe
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, parity
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, parity
    );
endinterface

// File: rtl/logic_unit_popcnt.sv
// rtl/logic_unit_popcnt.sv - iterative CHUNK-bits-per-cycle population counter (used under LOGIC_UNIT_POPCNT_EN)
module logic_unit_popcnt
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    localparam int CW   = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_active,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_done,
    output logic [CW-1:0]    o_count
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int SW    = clog2(STEPS + 1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_acc;
    logic [SW-1:0]    r_step;
    logic [CW-1:0]    w_chunk_sum;

    always_comb begin
        w_chunk_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk_sum = w_chunk_sum + CW'(r_shift[i]);
        end
    end

    // The final chunk is folded in combinationally so the result lands on the last COUNT edge.
    assign o_done  = i_active && (r_step == SW'(STEPS - 1));
    assign o_count = r_acc + w_chunk_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_step  <= '0;
        end else if (i_start) begin
            r_shift <= i_a;
            r_acc   <= '0;
            r_step  <= '0;
        end else if (i_active) begin
            r_acc   <= o_count;
            r_shift <= r_shift >> CHUNK;
            r_step  <= r_step + SW'(1);
        end
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered WIDTH-bit logic lane with handshake; LOGIC_UNIT_POPCNT_EN adds popcount on op 111
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    logic_unit_pipe_if.slave   bus
);
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_parity;
    logic             r_out_valid;

    logic             w_idle;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_next_y;

    always_comb begin
        w_result = '0;
        case (bus.op)
            OP_OR:          w_result = bus.a | bus.b;
            OP_AND:         w_result = bus.a & bus.b;
            OP_XOR:         w_result = bus.a ^ bus.b;
            OP_NOR:         w_result = ~(bus.a | bus.b);
            OP_NAND:        w_result = ~(bus.a & bus.b);
            OP_ANDN:        w_result = bus.a & ~bus.b;
            OP_PASSA:       w_result = bus.a;
`ifdef LOGIC_UNIT_POPCNT_EN
            OP_POPCNT_NOTA: w_result = '0;
`else
            OP_POPCNT_NOTA: w_result = ~bus.a;
`endif
            default:        w_result = '0;
        endcase
    end

    assign w_in_ready = w_idle && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int CW = clog2(WIDTH + 1);

    state_t        r_state;
    logic          w_start;
    logic          w_pc_done;
    logic [CW-1:0] w_pc_count;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_start = w_accept && (bus.op == OP_POPCNT_NOTA);

    logic_unit_popcnt #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_popcnt (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_active (r_state == ST_COUNT),
        .i_a      (bus.a),
        .o_done   (w_pc_done),
        .o_count  (w_pc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (w_start) begin
            r_state <= ST_COUNT;
        end else if (w_pc_done) begin
            r_state <= ST_IDLE;
        end
    end

    assign w_load   = (w_accept && !w_start) || w_pc_done;
    assign w_next_y = w_pc_done ? WIDTH'(w_pc_count) : w_result;
`else
    assign w_idle   = 1'b1;
    assign w_load   = w_accept;
    assign w_next_y = w_result;
`endif

    // A load always wins over a drain, so accept-while-draining keeps out_valid high with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_y         <= w_next_y;
            r_zero      <= ~|w_next_y;
            r_parity    <= ^w_next_y;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;
endmodule
